line_window_buf: RTL and testbench
==================================

LINE_WINDOW_BUF -- requirements
Module: line_window_buf

Interface
REQ-001 SHALL have parameter IMG_W, default 28, meaning pixels per image row (range 3..256).
REQ-002 SHALL have parameter IMG_H, default 28, meaning rows per frame (range 3..256).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 feature_valid  input  1  upstream sample strobe; a sample is presented this cycle.
REQ-006 feature_in  input  8  unsigned upstream pixel.
REQ-007 hold_data  output  1  stop request to upstream; frame fully received.
REQ-008 window_valid  output  1  single-cycle strobe; window_out holds a new 3x3 window.
REQ-009 window_out  output  72  3x3 window, row-major: [7:0]=(r-2,c-2), [15:8]=(r-2,c-1), ..., [71:64]=(r,c).
REQ-010 frame_done  output  1  level; high once the last window of the frame has been emitted.

Function
REQ-011 A pixel SHALL be accepted in a cycle where feature_valid=1 and the state is FILL or STREAM.
REQ-012 States SHALL be IDLE, FILL, STREAM and DONE.
REQ-013 IDLE SHALL go to FILL on the first clock after reset release, and SHALL accept no pixel.
REQ-014 FILL SHALL go to STREAM on accepting pixel (row 2, col 0).
REQ-015 STREAM SHALL go to DONE on accepting pixel (IMG_H-1, IMG_W-1).
REQ-016 DONE SHALL be terminal until reset.
REQ-017 A column counter 0..IMG_W-1 SHALL increment per accepted pixel and wrap to 0 after IMG_W-1.
REQ-018 A row counter 0..IMG_H-1 SHALL increment when the column counter wraps.
REQ-019 Both counters SHALL hold in cycles with no accept; gaps in feature_valid of any length SHALL be tolerated.
REQ-020 Two row buffers of depth IMG_W SHALL hold the previous two rows; three 3-entry column shift registers SHALL form the window.
REQ-021 Storage contents SHALL NOT be cleared at column wrap; windows straddling a row boundary SHALL be suppressed instead (REQ-022).
REQ-022 window_valid SHALL pulse high in the cycle after accepting pixel (r,c) if and only if r>=2 and c>=2.
REQ-023 Each frame SHALL produce exactly (IMG_W-2)*(IMG_H-2) windows; 676 at default.
REQ-024 window_out SHALL be registered, SHALL update only with window_valid, and SHALL hold its value otherwise.
REQ-025 Window latency SHALL be 1 clock from the accepting edge to window_valid high.
REQ-026 Pixel values SHALL pass unmodified: no arithmetic, sign extension or saturation.
REQ-027 hold_data SHALL be registered, rise in the cycle after the last pixel is accepted, and stay high until reset.
REQ-028 Upstream SHALL be expected to deliver up to 2 further strobes after hold_data rises; in DONE these SHALL be ignored with no change to counters, storage or outputs.
REQ-029 frame_done SHALL rise in the same cycle as the final window_valid pulse and stay high until reset.
REQ-030 A feature_valid pulse in the same cycle as the transition to DONE SHALL be treated per REQ-011, using the state before the edge.

Reset
REQ-031 While rst=0, the block SHALL force: state IDLE, counters 0, hold_data 0, window_valid 0, window_out 0, frame_done 0.
REQ-032 Row buffer and shift register contents SHALL be don't-care after reset; no window SHALL be emitted until they are refilled.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately, with no further window_valid pulse.
REQ-034 After a mid-frame reset, the next frame SHALL restart at pixel (0,0).

Verification
REQ-035 IMG_W=IMG_H=4; pixels 0..15 streamed back-to-back -> 4 windows.
  - First window: bytes 0,1,2,4,5,6,8,9,10, one cycle after pixel 10 is accepted.
  - Last window: bytes 5,6,7,9,10,11,13,14,15.
  - frame_done rises with the last window.
REQ-036 Same frame with feature_valid low every other cycle -> identical window values and count; window_valid occurs only after accept cycles.
REQ-037 Row-wrap check: no window_valid after accepting pixels 8 or 9 (c<2).
REQ-038 Upstream stop: hold_data rises one cycle after pixel 15 is accepted.
  - Apply 2 extra strobes carrying 0xAA -> no window_valid.
  - window_out unchanged; hold_data stays 1.
REQ-039 Reset at pixel 9, then release and resend 0..15 -> all outputs 0 during reset.
  - First post-reset window_valid occurs only after the new pixel 10.
REQ-040 Default 28x28 ramp (pixel = index mod 256) -> exactly 676 window_valid pulses.
  - hold_data=1 after pixel 783.

Source files
------------

// File: rtl/line_window_buf_if.sv
// Pixel-stream and window bundle for line_window_buf.
// The upstream source (master) drives the pixels, and the window buffer (slave) returns the windows.
interface line_window_buf_if;
    logic        feature_valid;
    logic [7:0]  feature_in;
    logic        hold_data;
    logic        window_valid;
    logic [71:0] window_out;
    logic        frame_done;

    modport master (
        output feature_valid, feature_in,
        input  hold_data, window_valid, window_out, frame_done
    );

    modport slave (
        input  feature_valid, feature_in,
        output hold_data, window_valid, window_out, frame_done
    );
endinterface

// File: rtl/line_window_buf.sv
// Streaming 3x3 window generator: two row buffers plus column shift registers.
// The block emits one registered window per accepted pixel whose row and column are both at least 2.
module line_window_buf #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic              clk,
    input  logic              rst,
    line_window_buf_if.slave  bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          hold_q;
    logic          valid_q;
    logic          done_q;
    logic [71:0]   window_q;

    logic [7:0] line0 [IMG_W];   // row r-2
    logic [7:0] line1 [IMG_W];   // row r-1
    logic [7:0] top_q [2];
    logic [7:0] mid_q [2];
    logic [7:0] bot_q [2];

    logic        accept;
    logic        col_last;
    logic        row_last;
    logic        in_window;
    logic [7:0]  top_new;
    logic [7:0]  mid_new;
    logic [71:0] window_d;

    always_comb begin
        accept    = bus.feature_valid && (state == FILL || state == STREAM);
        col_last  = (col == COL_LAST);
        row_last  = (row == ROW_LAST);
        in_window = (row >= RW'(2)) && (col >= CW'(2));
        top_new   = line0[col];
        mid_new   = line1[col];
        // The live column is the head of each 3-entry shift register, so the window includes the pixel being accepted.
        window_d  = {bus.feature_in, bot_q[0], bot_q[1],
                     mid_new,        mid_q[0], mid_q[1],
                     top_new,        top_q[0], top_q[1]};
    end

    // NOTE: pixel storage has no reset; stale contents are harmless because windows are gated until rows 0..2 are refilled.
    always_ff @(posedge clk) begin
        if (accept) begin
            line0[col] <= line1[col];
            line1[col] <= bus.feature_in;
            top_q[0]   <= top_new;
            top_q[1]   <= top_q[0];
            mid_q[0]   <= mid_new;
            mid_q[1]   <= mid_q[0];
            bot_q[0]   <= bus.feature_in;
            bot_q[1]   <= bot_q[0];
        end
    end

    // NOTE: all state uses non-blocking assignments so every read sees the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            hold_q   <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            window_q <= '0;
        end else begin
            valid_q <= accept && in_window;
            if (accept && in_window)
                window_q <= window_d;

            if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            case (state)
                IDLE:   state <= FILL;
                FILL:   if (accept && row == RW'(2) && col == '0)
                            state <= STREAM;
                STREAM: if (accept && row_last && col_last) begin
                            state  <= DONE;
                            hold_q <= 1'b1;
                            done_q <= 1'b1;
                        end
                default: state <= DONE;
            endcase
        end
    end

    assign bus.hold_data    = hold_q;
    assign bus.window_valid = valid_q;
    assign bus.window_out   = window_q;
    assign bus.frame_done   = done_q;
endmodule

// File: tb/tb_line_window_buf.sv
// Bench for line_window_buf: a 4x4 instance driven from a vector table and a default 28x28 instance driven with a ramp.
// Expected windows go into per-instance queues when pixels are driven and are popped when window_valid fires.
module tb_line_window_buf;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    line_window_buf_if s_if ();
    line_window_buf_if d_if ();

    line_window_buf #(.IMG_W(4), .IMG_H(4)) u_small (.clk(clk), .rst(rst), .bus(s_if.slave));
    line_window_buf                         u_dflt  (.clk(clk), .rst(rst), .bus(d_if.slave));

    typedef struct {
        logic [7:0]  pix;
        logic        exp_wv;
        logic        exp_hold;
        logic        exp_fd;
        logic [71:0] exp_win;
    } vec_t;

    vec_t        tv [16];
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_win_s = 0;
    int          n_win_d = 0;
    logic [71:0] q_s [$];
    logic [71:0] q_d [$];
    logic [71:0] last_win_s = '0;

    function automatic logic [71:0] calc_win(int w, int r, int c);
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[(i*3+j)*8 +: 8] = 8'((r - 2 + i) * w + (c - 2 + j));
        return v;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and compare any window that either instance produced against its queue.
    task automatic tick();
        logic [71:0] e;
        @(posedge clk);
        #1;
        if (s_if.window_valid) begin
            n_win_s++;
            check("small_window_expected", q_s.size() != 0, 1'b1);
            if (q_s.size() != 0) begin
                e = q_s.pop_front();
                last_win_s = e;
                check("small_window", s_if.window_out, e);
            end
        end
        if (d_if.window_valid) begin
            n_win_d++;
            check("dflt_window_expected", q_d.size() != 0, 1'b1);
            if (q_d.size() != 0) begin
                e = q_d.pop_front();
                check("dflt_window", d_if.window_out, e);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        s_if.feature_valid = 1'b0;
        d_if.feature_valid = 1'b0;
        q_s.delete();
        q_d.delete();
        last_win_s = '0;
        #1;
        check("rst_small_hold", s_if.hold_data, 1'b0);
        check("rst_small_wv", s_if.window_valid, 1'b0);
        check("rst_small_win", s_if.window_out, '0);
        check("rst_small_fd", s_if.frame_done, 1'b0);
        check("rst_dflt_hold", d_if.hold_data, 1'b0);
        check("rst_dflt_wv", d_if.window_valid, 1'b0);
        check("rst_dflt_win", d_if.window_out, '0);
        check("rst_dflt_fd", d_if.frame_done, 1'b0);
        tick();
        check("rst_held_wv", s_if.window_valid, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_small(input int first, input int last, input bit gap);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            s_if.feature_valid = 1'b1;
            s_if.feature_in    = tv[i].pix;
            if (tv[i].exp_wv)
                q_s.push_back(tv[i].exp_win);
            tick();
            check($sformatf("wv_px%0d", i), s_if.window_valid, tv[i].exp_wv);
            check($sformatf("hold_px%0d", i), s_if.hold_data, tv[i].exp_hold);
            check($sformatf("fd_px%0d", i), s_if.frame_done, tv[i].exp_fd);
            if (gap) begin
                @(negedge clk);
                s_if.feature_valid = 1'b0;
                s_if.feature_in    = 8'h55;
                tick();
                check($sformatf("gap_wv_px%0d", i), s_if.window_valid, 1'b0);
                check($sformatf("gap_hold_win_px%0d", i), s_if.window_out, last_win_s);
            end
        end
        @(negedge clk);
        s_if.feature_valid = 1'b0;
    endtask

    initial begin
        int base;
        rst = 1'b0;
        s_if.feature_valid = 1'b0;
        s_if.feature_in    = 8'h00;
        d_if.feature_valid = 1'b0;
        d_if.feature_in    = 8'h00;

        for (int i = 0; i < 16; i++) begin
            tv[i].pix      = 8'(i);
            tv[i].exp_wv   = (i / 4 >= 2) && (i % 4 >= 2);
            tv[i].exp_hold = (i == 15);
            tv[i].exp_fd   = (i == 15);
            tv[i].exp_win  = calc_win(4, i / 4, i % 4);
        end

        // Back-to-back 4x4 frame, with a stray strobe during the IDLE cycle that must not be taken.
        apply_reset();
        s_if.feature_valid = 1'b1;
        s_if.feature_in    = 8'hEE;
        base = n_win_s;
        tick();
        check("idle_wv", s_if.window_valid, 1'b0);
        send_small(0, 15, 1'b0);
        check("last_window", s_if.window_out, 72'h0f0e0d0b0a09070605);
        check("frame_count", n_win_s - base, 4);
        check("frame_queue_empty", q_s.size(), 0);

        // Strobes after hold_data are ignored in DONE.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            s_if.feature_valid = 1'b1;
            s_if.feature_in    = 8'hAA;
            tick();
            check("extra_wv", s_if.window_valid, 1'b0);
            check("extra_win", s_if.window_out, 72'h0f0e0d0b0a09070605);
            check("extra_hold", s_if.hold_data, 1'b1);
            check("extra_fd", s_if.frame_done, 1'b1);
        end
        @(negedge clk);
        s_if.feature_valid = 1'b0;
        tick();
        check("extra_count", n_win_s - base, 4);

        // Same frame with a one-cycle gap after each pixel.
        apply_reset();
        base = n_win_s;
        send_small(0, 15, 1'b1);
        check("gap_count", n_win_s - base, 4);
        check("gap_last_window", s_if.window_out, 72'h0f0e0d0b0a09070605);

        // Reset after pixel 9, then resend the whole frame from (0,0).
        apply_reset();
        send_small(0, 9, 1'b0);
        apply_reset();
        base = n_win_s;
        send_small(0, 15, 1'b0);
        check("rerun_count", n_win_s - base, 4);
        check("rerun_queue_empty", q_s.size(), 0);

        // Default 28x28 ramp on the second instance.
        base = n_win_d;
        for (int i = 0; i < 784; i++) begin
            @(negedge clk);
            d_if.feature_valid = 1'b1;
            d_if.feature_in    = 8'(i);
            if ((i / 28 >= 2) && (i % 28 >= 2))
                q_d.push_back(calc_win(28, i / 28, i % 28));
            tick();
            if (i == 782) check("dflt_hold_before_last", d_if.hold_data, 1'b0);
            if (i == 783) begin
                check("dflt_hold_after_last", d_if.hold_data, 1'b1);
                check("dflt_fd_after_last", d_if.frame_done, 1'b1);
                check("dflt_wv_last", d_if.window_valid, 1'b1);
            end
        end
        @(negedge clk);
        d_if.feature_valid = 1'b0;
        tick();
        check("dflt_count", n_win_d - base, 676);
        check("dflt_queue_empty", q_d.size(), 0);
        check("dflt_hold_stays", d_if.hold_data, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
